// File: rtl/mt_fetch_sched_pkg.sv
// mt_pkg: shared constants and one-hot/index/rotate-priority helpers for the fetch scheduler
package mt_pkg;
  localparam int MAX_T = 16;
  localparam int PC_INCR_DEF = 4;
  function automatic logic [MAX_T-1:0] to_onehot(input int idx);
    logic [MAX_T-1:0] r;
    r = '0;
    r[idx[3:0]] = 1'b1;
    return r;
  endfunction
  function automatic int to_index(input logic [MAX_T-1:0] oh);
    int r;
    r = 0;
    for (int i = 0; i < MAX_T; i++) if (oh[i]) r = r | i;
    return r;
  endfunction
  // first set bit of mask in order cur+1 .. cur (wrapping), -1 when mask is empty
  function automatic int rot_pick(input logic [MAX_T-1:0] mask, input int cur, input int n);
    int r;
    int j;
    r = -1;
    for (int k = n; k >= 1; k--) begin
      j = (cur + k) % n;
      if (mask[j]) r = j;
    end
    return r;
  endfunction
endpackage

// File: rtl/mt_fetch_sched_if.sv
// mt_fetch_sched_if: scheduler control, redirect, fetch issue and debug signals
interface mt_fetch_sched_if #(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH = 32,
  parameter int TID_W = $clog2(NUM_THREADS)
);
  logic fetch_en;
  logic [NUM_THREADS-1:0] thread_en;
  logic redirect_valid;
  logic [NUM_THREADS-1:0] redirect_thread;
  logic [PC_WIDTH-1:0] redirect_pc;
  logic fetch_valid;
  logic [PC_WIDTH-1:0] fetch_pc;
  logic [NUM_THREADS-1:0] fetch_thread;
  logic redirect_err;
  logic [TID_W-1:0] dbg_tid;
  logic [PC_WIDTH-1:0] dbg_pc;
  modport master (
    output fetch_en, thread_en, redirect_valid, redirect_thread, redirect_pc, dbg_tid,
    input fetch_valid, fetch_pc, fetch_thread, redirect_err, dbg_pc
  );
  modport slave (
    input fetch_en, thread_en, redirect_valid, redirect_thread, redirect_pc, dbg_tid,
    output fetch_valid, fetch_pc, fetch_thread, redirect_err, dbg_pc
  );
endinterface

// File: rtl/mt_fetch_sched_rr_pick.sv
// rr_pick: rotating priority picker, the thread after cur has highest priority and cur lowest
module rr_pick import mt_pkg::*; #(
  parameter int N = 4
) (
  input  logic [N-1:0] mask,
  input  logic [N-1:0] cur,
  output logic [N-1:0] next,
  output logic found
);
  int idx;
  // search from the slot after the last-issued thread, wrapping back to it
  always_comb begin
    idx = rot_pick(MAX_T'(mask), to_index(MAX_T'(cur)), N);
    found = idx >= 0;
    next = found ? N'(to_onehot(idx)) : '0;
  end
endmodule

// File: rtl/mt_fetch_sched.sv
// mt_fetch_sched: per-thread PC file with round-robin fetch issue and MEM-stage redirects
module mt_fetch_sched import mt_pkg::*; #(
  parameter int NUM_THREADS = 4,
  parameter int PC_WIDTH = 32,
  parameter int RESET_BASE = 0,
  parameter int RESET_STRIDE = 4,
  parameter int PC_INCR = PC_INCR_DEF,
  parameter int TID_W = $clog2(NUM_THREADS)
) (
  input logic clk,
  input logic reset,
  mt_fetch_sched_if.slave bus
);
  logic [PC_WIDTH-1:0] pc [NUM_THREADS];
  logic [NUM_THREADS-1:0] cur, nxt;
  logic found, rd_oh, rd_ok, issue;
  logic [PC_WIDTH-1:0] rd_pc, sel_pc, iss_pc, dbg;
  rr_pick #(.N(NUM_THREADS)) u_pick (.mask(bus.thread_en), .cur(cur), .next(nxt), .found(found));
  // redirect qualification, selected PC with same-cycle redirect bypass, debug readback
  always_comb begin
    rd_oh = $onehot(bus.redirect_thread);
    rd_ok = bus.redirect_valid && rd_oh;
    rd_pc = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
    issue = bus.fetch_en && found;
    sel_pc = '0;
    dbg = '0;
    for (int i = 0; i < NUM_THREADS; i++) begin
      sel_pc = sel_pc | (nxt[i] ? pc[i] : '0);
      if (bus.dbg_tid == TID_W'(i)) dbg = pc[i];
    end
    iss_pc = (rd_ok && bus.redirect_thread == nxt) ? rd_pc : sel_pc;
  end
  assign bus.dbg_pc = dbg;
  // issue registers, last-issued pointer, sticky error and PC updates; redirects apply even when stalled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur <= NUM_THREADS'(1) << (NUM_THREADS - 1);
      bus.fetch_valid <= 1'b0;
      bus.fetch_pc <= '0;
      bus.fetch_thread <= '0;
      bus.redirect_err <= 1'b0;
      for (int i = 0; i < NUM_THREADS; i++) pc[i] <= PC_WIDTH'(RESET_BASE + i * RESET_STRIDE);
    end else begin
      bus.redirect_err <= bus.redirect_err | (bus.redirect_valid && (!rd_oh || bus.redirect_pc[1:0] != 2'b00));
      if (bus.fetch_en) begin
        bus.fetch_valid <= found;
        bus.fetch_thread <= found ? nxt : '0;
        if (found) begin
          bus.fetch_pc <= iss_pc;
          cur <= nxt;
        end
      end
      for (int i = 0; i < NUM_THREADS; i++)
        if (issue && nxt[i]) pc[i] <= iss_pc + PC_WIDTH'(PC_INCR);
        else if (rd_ok && bus.redirect_thread[i]) pc[i] <= rd_pc;
    end
  end
endmodule

// File: tb/tb_mt_fetch_sched.sv
// tb_mt_fetch_sched: directed checks of issue order, redirects, stalls, masking and errors
module tb_mt_fetch_sched;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int vecs = 0;
  int errs = 0;
  mt_fetch_sched_if #(.NUM_THREADS(4), .PC_WIDTH(32)) bus ();
  mt_fetch_sched dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fetch_en = 1'b0;
    bus.thread_en = 4'b0000;
    bus.redirect_valid = 1'b0;
    bus.redirect_thread = 4'b0000;
    bus.redirect_pc = 32'h0;
    bus.dbg_tid = 2'd0;
  endtask

  task automatic test_reset();
    logic [31:0] rp [4] = '{32'h0, 32'h4, 32'h8, 32'hC};
    idle_inputs();
    reset = 1'b1;
    tick();
    vecs++;
    if (bus.fetch_valid !== 1'b0 || bus.fetch_pc !== 32'h0 || bus.fetch_thread !== 4'b0 || bus.redirect_err !== 1'b0) begin
      errs++;
      $display("FAIL reset_out: got v=%b pc=%h th=%b err=%b exp 0/0/0/0", bus.fetch_valid, bus.fetch_pc, bus.fetch_thread, bus.redirect_err);
    end
    for (int i = 0; i < 4; i++) begin
      bus.dbg_tid = 2'(i);
      #1;
      vecs++;
      if (bus.dbg_pc !== rp[i]) begin
        errs++;
        $display("FAIL reset_pc[%0d]: got %h exp %h", i, bus.dbg_pc, rp[i]);
      end
    end
    bus.dbg_tid = 2'd0;
    reset = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [31:0] ep [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h4, 32'h8, 32'hC, 32'h10};
    logic [3:0] et [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bus.fetch_en = 1'b1;
    bus.thread_en = 4'b1111;
    for (int i = 0; i < 8; i++) begin
      tick();
      vecs++;
      if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== ep[i] || bus.fetch_thread !== et[i % 4]) begin
        errs++;
        $display("FAIL rr[%0d]: got v=%b pc=%h th=%b exp 1 %h %b", i, bus.fetch_valid, bus.fetch_pc, bus.fetch_thread, ep[i], et[i % 4]);
      end
    end
  endtask

  task automatic test_masked();
    logic [31:0] ep [4] = '{32'h0, 32'h8, 32'h4, 32'hC};
    logic [3:0] et [2] = '{4'b0001, 4'b0100};
    bus.fetch_en = 1'b1;
    bus.thread_en = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      tick();
      vecs++;
      if (bus.fetch_pc !== ep[i] || bus.fetch_thread !== et[i % 2]) begin
        errs++;
        $display("FAIL mask[%0d]: got pc=%h th=%b exp %h %b", i, bus.fetch_pc, bus.fetch_thread, ep[i], et[i % 2]);
      end
    end
  endtask

  task automatic test_redirect_bypass();
    logic [31:0] ep [5] = '{32'h100, 32'h8, 32'hC, 32'h4, 32'h104};
    logic [3:0] et [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    bus.fetch_en = 1'b1;
    bus.thread_en = 4'b1111;
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_thread = 4'b0010;
    bus.redirect_pc = 32'h100;
    for (int i = 0; i < 5; i++) begin
      tick();
      bus.redirect_valid = 1'b0;
      vecs++;
      if (bus.fetch_pc !== ep[i] || bus.fetch_thread !== et[i]) begin
        errs++;
        $display("FAIL bypass[%0d]: got pc=%h th=%b exp %h %b", i, bus.fetch_pc, bus.fetch_thread, ep[i], et[i]);
      end
    end
    vecs++;
    if (bus.redirect_err !== 1'b0) begin
      errs++;
      $display("FAIL bypass_err: got %b exp 0", bus.redirect_err);
    end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] ep [3] = '{32'h4, 32'h8, 32'h200};
    logic [3:0] et [3] = '{4'b0010, 4'b0100, 4'b1000};
    bus.fetch_en = 1'b1;
    bus.thread_en = 4'b1111;
    tick();
    bus.fetch_en = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_thread = 4'b1000;
    bus.redirect_pc = 32'h200;
    for (int i = 0; i < 3; i++) begin
      tick();
      bus.redirect_valid = 1'b0;
      vecs++;
      if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h0 || bus.fetch_thread !== 4'b0001) begin
        errs++;
        $display("FAIL stall[%0d]: got v=%b pc=%h th=%b exp 1 00000000 0001", i, bus.fetch_valid, bus.fetch_pc, bus.fetch_thread);
      end
    end
    bus.dbg_tid = 2'd3;
    #1;
    vecs++;
    if (bus.dbg_pc !== 32'h200) begin
      errs++;
      $display("FAIL stall_dbg3: got %h exp 00000200", bus.dbg_pc);
    end
    bus.fetch_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (bus.fetch_pc !== ep[i] || bus.fetch_thread !== et[i]) begin
        errs++;
        $display("FAIL resume[%0d]: got pc=%h th=%b exp %h %b", i, bus.fetch_pc, bus.fetch_thread, ep[i], et[i]);
      end
    end
  endtask

  task automatic test_none_runnable();
    bus.fetch_en = 1'b1;
    bus.thread_en = 4'b1111;
    tick();
    bus.thread_en = 4'b0000;
    tick();
    vecs++;
    if (bus.fetch_valid !== 1'b0 || bus.fetch_thread !== 4'b0 || bus.fetch_pc !== 32'h0) begin
      errs++;
      $display("FAIL none: got v=%b pc=%h th=%b exp 0 00000000 0000", bus.fetch_valid, bus.fetch_pc, bus.fetch_thread);
    end
    bus.thread_en = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (bus.fetch_valid !== 1'b1 || bus.fetch_pc !== 32'h8 + 32'(4 * i) || bus.fetch_thread !== 4'b0100) begin
        errs++;
        $display("FAIL single[%0d]: got v=%b pc=%h th=%b exp 1 %h 0100", i, bus.fetch_valid, bus.fetch_pc, bus.fetch_thread, 32'h8 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_bad_redirect();
    bus.redirect_valid = 1'b1;
    bus.redirect_thread = 4'b0011;
    bus.redirect_pc = 32'h300;
    tick();
    bus.redirect_valid = 1'b0;
    tick();
    vecs++;
    if (bus.redirect_err !== 1'b1) begin
      errs++;
      $display("FAIL err_sticky: got %b exp 1", bus.redirect_err);
    end
    for (int i = 0; i < 2; i++) begin
      bus.dbg_tid = 2'(i);
      #1;
      vecs++;
      if (bus.dbg_pc !== 32'(4 * i)) begin
        errs++;
        $display("FAIL err_nochange[%0d]: got %h exp %h", i, bus.dbg_pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_misaligned();
    bus.redirect_valid = 1'b1;
    bus.redirect_thread = 4'b0100;
    bus.redirect_pc = 32'h102;
    tick();
    bus.redirect_valid = 1'b0;
    bus.dbg_tid = 2'd2;
    #1;
    vecs++;
    if (bus.redirect_err !== 1'b1 || bus.dbg_pc !== 32'h100) begin
      errs++;
      $display("FAIL misalign: got err=%b pc=%h exp 1 00000100", bus.redirect_err, bus.dbg_pc);
    end
  endtask

  task automatic test_wrap();
    bus.redirect_valid = 1'b1;
    bus.redirect_thread = 4'b0001;
    bus.redirect_pc = 32'hFFFF_FFFC;
    tick();
    bus.redirect_valid = 1'b0;
    bus.fetch_en = 1'b1;
    bus.thread_en = 4'b0001;
    tick();
    vecs++;
    if (bus.fetch_pc !== 32'hFFFF_FFFC) begin
      errs++;
      $display("FAIL wrap0: got %h exp fffffffc", bus.fetch_pc);
    end
    tick();
    vecs++;
    if (bus.fetch_pc !== 32'h0 || bus.fetch_thread !== 4'b0001) begin
      errs++;
      $display("FAIL wrap1: got pc=%h th=%b exp 00000000 0001", bus.fetch_pc, bus.fetch_thread);
    end
  endtask

  task automatic test_async_reset();
    bus.fetch_en = 1'b1;
    bus.thread_en = 4'b1111;
    bus.redirect_valid = 1'b1;
    bus.redirect_thread = 4'b0001;
    bus.redirect_pc = 32'h500;
    @(negedge clk);
    reset = 1'b1;
    #1;
    vecs++;
    if (bus.fetch_valid !== 1'b0 || bus.redirect_err !== 1'b0 || bus.fetch_thread !== 4'b0) begin
      errs++;
      $display("FAIL async_reset: got v=%b err=%b th=%b exp 0 0 0000", bus.fetch_valid, bus.redirect_err, bus.fetch_thread);
    end
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    tick();
    vecs++;
    if (bus.fetch_pc !== 32'h0 || bus.fetch_thread !== 4'b0001) begin
      errs++;
      $display("FAIL post_reset: got pc=%h th=%b exp 00000000 0001", bus.fetch_pc, bus.fetch_thread);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_reset();
    test_masked();
    test_reset();
    test_redirect_bypass();
    test_reset();
    test_stall_redirect();
    test_reset();
    test_none_runnable();
    test_reset();
    test_bad_redirect();
    test_reset();
    test_misaligned();
    test_reset();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
